// File: rtl/tuner_phy_pwr_detect.sv
// Tuner PHY power detector: settle after a code update, average 2^AVG_LOG2 ADC samples, report the result.
// Optional peak tracking is enabled by defining TUNER_PHY_DETECT_PEAK_EN.
module tuner_phy_pwr_detect #(
   parameter int ADC_WIDTH  = 8,
   parameter int CODE_WIDTH = 8,
   parameter int AVG_LOG2   = 2,
   parameter int WAIT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [CODE_WIDTH-1:0] i_code,
   input  logic [WAIT_WIDTH-1:0] i_cfg_wait,
   input  logic                  i_adc_valid,
   input  logic [ADC_WIDTH-1:0]  i_adc_data,
   input  logic                  i_err_clr,
`ifdef TUNER_PHY_DETECT_PEAK_EN
   input  logic                  i_peak_clr,
   output logic [ADC_WIDTH-1:0]  o_peak_pwr,
   output logic [CODE_WIDTH-1:0] o_peak_code,
`endif
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ADC_WIDTH-1:0]  o_pwr,
   output logic [CODE_WIDTH-1:0] o_code,
   output logic                  o_err_multi,
   output logic [2:0]            o_state
);

   localparam int ACC_W = ADC_WIDTH + AVG_LOG2;

   typedef enum logic [2:0] {
      DETECT_IDLE   = 3'd0,
      DETECT_WAIT   = 3'd1,
      DETECT_ACTIVE = 3'd2,
      DETECT_DONE   = 3'd3
   } tuner_phy_detect_state_e;

   tuner_phy_detect_state_e state_r;
   logic [WAIT_WIDTH-1:0]   wait_cnt_r;
   logic [AVG_LOG2-1:0]     smp_cnt_r;
   logic [ACC_W-1:0]        acc_r;
   logic [CODE_WIDTH-1:0]   code_r;

   logic [ACC_W-1:0]        acc_sum_s;
   logic                    smp_last_s;
   logic                    err_set_s;

   // Accumulator sum and control decodes used by the FSM and error flag.
   always_comb begin
      acc_sum_s  = acc_r + ACC_W'(i_adc_data);
      smp_last_s = (smp_cnt_r == {AVG_LOG2{1'b1}});
      err_set_s  = i_start && (state_r != DETECT_IDLE);
   end

   // Detection FSM with its datapath registers and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= DETECT_IDLE;
         wait_cnt_r <= '0;
         smp_cnt_r  <= '0;
         acc_r      <= '0;
         code_r     <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_pwr      <= '0;
         o_code     <= '0;
      end else begin
         case (state_r)
            DETECT_IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  code_r     <= i_code;
                  wait_cnt_r <= i_cfg_wait;
                  acc_r      <= '0;
                  smp_cnt_r  <= '0;
                  o_busy     <= 1'b1;
                  // A zero settling time skips WAIT entirely.
                  if (i_cfg_wait != '0) begin
                     state_r <= DETECT_WAIT;
                  end else begin
                     state_r <= DETECT_ACTIVE;
                  end
               end else begin
                  o_busy <= 1'b0;
               end
            end
            DETECT_WAIT: begin
               o_done     <= 1'b0;
               o_busy     <= 1'b1;
               wait_cnt_r <= wait_cnt_r - WAIT_WIDTH'(1);
               if (wait_cnt_r == WAIT_WIDTH'(1)) begin
                  state_r <= DETECT_ACTIVE;
               end
            end
            DETECT_ACTIVE: begin
               o_busy <= 1'b1;
               o_done <= 1'b0;
               if (i_adc_valid) begin
                  acc_r     <= acc_sum_s;
                  smp_cnt_r <= smp_cnt_r + AVG_LOG2'(1);
                  if (smp_last_s) begin
                     state_r <= DETECT_DONE;
                     o_done  <= 1'b1;
                     o_pwr   <= acc_sum_s[ACC_W-1:AVG_LOG2];
                     o_code  <= code_r;
                  end
               end
            end
            DETECT_DONE: begin
               state_r <= DETECT_IDLE;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
            end
            default: begin
               state_r <= DETECT_IDLE;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky multi-start error; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_err_multi <= 1'b0;
      end else if (err_set_s) begin
         o_err_multi <= 1'b1;
      end else if (i_err_clr) begin
         o_err_multi <= 1'b0;
      end
   end

`ifdef TUNER_PHY_DETECT_PEAK_EN
   // Peak tracker: strictly-greater update keeps the earlier code on ties; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_peak_pwr  <= '0;
         o_peak_code <= '0;
      end else if (i_peak_clr) begin
         o_peak_pwr  <= '0;
         o_peak_code <= '0;
      end else if (o_done && (o_pwr > o_peak_pwr)) begin
         o_peak_pwr  <= o_pwr;
         o_peak_code <= o_code;
      end
   end
`endif

   assign o_state = state_r;

endmodule

// File: tb/tb_tuner_phy_pwr_detect.sv
// Directed self-checking bench for tuner_phy_pwr_detect (peak checks when TUNER_PHY_DETECT_PEAK_EN is defined).
module tb_tuner_phy_pwr_detect;

   logic       clk;
   logic       rst_n;
   logic       i_start;
   logic [7:0] i_code;
   logic [7:0] i_cfg_wait;
   logic       i_adc_valid;
   logic [7:0] i_adc_data;
   logic       i_err_clr;
   logic       o_busy;
   logic       o_done;
   logic [7:0] o_pwr;
   logic [7:0] o_code;
   logic       o_err_multi;
   logic [2:0] o_state;
`ifdef TUNER_PHY_DETECT_PEAK_EN
   logic       i_peak_clr;
   logic [7:0] o_peak_pwr;
   logic [7:0] o_peak_code;
`endif

   int pass_cnt  = 0;
   int check_cnt = 0;

   tuner_phy_pwr_detect dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_code      (i_code),
      .i_cfg_wait  (i_cfg_wait),
      .i_adc_valid (i_adc_valid),
      .i_adc_data  (i_adc_data),
      .i_err_clr   (i_err_clr),
`ifdef TUNER_PHY_DETECT_PEAK_EN
      .i_peak_clr  (i_peak_clr),
      .o_peak_pwr  (o_peak_pwr),
      .o_peak_code (o_peak_code),
`endif
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_pwr       (o_pwr),
      .o_code      (o_code),
      .o_err_multi (o_err_multi),
      .o_state     (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one detection with start in cycle 0; cycle c is the interval after the c-th rising edge.
   task automatic run_det(input logic [7:0] code, input logic [7:0] w,
                          input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3,
                          input bit gap, input bit wstrobe,
                          input int start_at, input int clr_at,
                          output int done_cyc, output logic [7:0] pwr,
                          output logic [7:0] codeo, output int busy_cnt,
                          output logic busy_after, output logic [2:0] st_first);
      logic [7:0] s [4];
      int  idx;
      int  c;
      bit  seen;
      s = '{s0, s1, s2, s3};
      idx = 0; c = 0; seen = 1'b0;
      done_cyc = 0; pwr = 8'h00; codeo = 8'h00; busy_cnt = 0;
      busy_after = 1'b1; st_first = 3'd7;
      i_start = 1'b1; i_code = code; i_cfg_wait = w;
      i_adc_valid = 1'b0; i_adc_data = 8'h00;
      while (c < 40 && !(seen && c > done_cyc)) begin
         tick;
         c++;
         i_start = 1'b0;
         i_err_clr = 1'b0;
         if (c == start_at) begin
            i_start = 1'b1; i_code = 8'h99; i_cfg_wait = 8'd0;
         end
         if (c == clr_at) i_err_clr = 1'b1;
         if (o_busy) busy_cnt++;
         if (c == int'(w) + 1) st_first = o_state;
         if (seen && c == done_cyc + 1) busy_after = o_busy;
         if (o_done && !seen) begin
            seen = 1'b1; done_cyc = c; pwr = o_pwr; codeo = o_code;
         end
         i_adc_valid = 1'b0;
         i_adc_data  = 8'hEE;
         if (c <= int'(w)) begin
            if (wstrobe) begin
               i_adc_valid = 1'b1; i_adc_data = 8'hFF;
            end
         end else if (idx < 4 && (!gap || ((c - int'(w) - 1) % 2 == 0))) begin
            i_adc_valid = 1'b1; i_adc_data = s[idx]; idx++;
         end
      end
      i_start = 1'b0; i_err_clr = 1'b0; i_adc_valid = 1'b0;
   endtask

   int         d_cyc;
   logic [7:0] d_pwr;
   logic [7:0] d_code;
   int         d_busy;
   logic       d_bafter;
   logic [2:0] d_st;

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      check_cnt++;
      if ({o_busy, o_done, o_pwr, o_code, o_err_multi, o_state} !== 22'd0)
         $display("FAIL reset_outputs: got busy=%b done=%b pwr=%h code=%h err=%b state=%0d, want all 0",
                  o_busy, o_done, o_pwr, o_code, o_err_multi, o_state);
      else pass_cnt++;
      #10;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_settled;
      run_det(8'h42, 8'd3, 8'd10, 8'd20, 8'd30, 8'd41, 1'b0, 1'b0, 0, 0,
              d_cyc, d_pwr, d_code, d_busy, d_bafter, d_st);
      check_cnt++;
      if (d_cyc !== 8) $display("FAIL settled_done_cycle: got %0d want 8", d_cyc); else pass_cnt++;
      check_cnt++;
      if (d_pwr !== 8'd25) $display("FAIL settled_pwr: got %0d want 25", d_pwr); else pass_cnt++;
      check_cnt++;
      if (d_code !== 8'h42) $display("FAIL settled_code: got %h want 42", d_code); else pass_cnt++;
      check_cnt++;
      if (d_busy !== 8) $display("FAIL settled_busy_cycles: got %0d want 8", d_busy); else pass_cnt++;
      check_cnt++;
      if (d_bafter !== 1'b0) $display("FAIL settled_busy_fall: got %b want 0", d_bafter); else pass_cnt++;
      check_cnt++;
      if (d_st !== 3'd2) $display("FAIL settled_active_cycle4: got %0d want 2", d_st); else pass_cnt++;
   endtask

   task automatic test_zero_wait;
      run_det(8'h07, 8'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 0, 0,
              d_cyc, d_pwr, d_code, d_busy, d_bafter, d_st);
      check_cnt++;
      if (d_st !== 3'd2) $display("FAIL zero_active_cycle1: got %0d want 2", d_st); else pass_cnt++;
      check_cnt++;
      if (d_cyc !== 5) $display("FAIL zero_done_cycle: got %0d want 5", d_cyc); else pass_cnt++;
      check_cnt++;
      if (d_pwr !== 8'hFF) $display("FAIL zero_pwr: got %h want ff", d_pwr); else pass_cnt++;
      check_cnt++;
      if (d_code !== 8'h07) $display("FAIL zero_code: got %h want 07", d_code); else pass_cnt++;
   endtask

   task automatic test_gapped;
      run_det(8'h5A, 8'd2, 8'd8, 8'd16, 8'd24, 8'd33, 1'b1, 1'b1, 0, 0,
              d_cyc, d_pwr, d_code, d_busy, d_bafter, d_st);
      check_cnt++;
      if (d_cyc !== 10) $display("FAIL gapped_done_cycle: got %0d want 10", d_cyc); else pass_cnt++;
      check_cnt++;
      if (d_pwr !== 8'd20) $display("FAIL gapped_pwr: got %0d want 20", d_pwr); else pass_cnt++;
      check_cnt++;
      if (o_err_multi !== 1'b0) $display("FAIL gapped_no_err: got %b want 0", o_err_multi); else pass_cnt++;
   endtask

   task automatic test_start_while_busy;
      run_det(8'h11, 8'd3, 8'd40, 8'd40, 8'd40, 8'd44, 1'b0, 1'b0, 2, 2,
              d_cyc, d_pwr, d_code, d_busy, d_bafter, d_st);
      check_cnt++;
      if (o_err_multi !== 1'b1) $display("FAIL busy_err_set_wins: got %b want 1", o_err_multi); else pass_cnt++;
      check_cnt++;
      if (d_cyc !== 8) $display("FAIL busy_done_cycle: got %0d want 8", d_cyc); else pass_cnt++;
      check_cnt++;
      if (d_pwr !== 8'd41) $display("FAIL busy_pwr: got %0d want 41", d_pwr); else pass_cnt++;
      check_cnt++;
      if (d_code !== 8'h11) $display("FAIL busy_code: got %h want 11", d_code); else pass_cnt++;
      check_cnt++;
      if (d_bafter !== 1'b0) $display("FAIL busy_no_restart: got %b want 0", d_bafter); else pass_cnt++;
      i_err_clr = 1'b1;
      tick;
      i_err_clr = 1'b0;
      check_cnt++;
      if (o_err_multi !== 1'b0) $display("FAIL busy_err_clear: got %b want 0", o_err_multi); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      i_start = 1'b1; i_code = 8'h55; i_cfg_wait = 8'd1;
      tick;
      i_start = 1'b0;
      tick;
      i_adc_valid = 1'b1; i_adc_data = 8'h80;
      tick;
      tick;
      check_cnt++;
      if (o_state !== 3'd2) $display("FAIL rstmid_in_active: got %0d want 2", o_state); else pass_cnt++;
      #1;
      rst_n = 1'b0;
      #1;
      check_cnt++;
      if ({o_busy, o_done, o_pwr, o_code, o_err_multi, o_state} !== 22'd0)
         $display("FAIL rstmid_outputs: got busy=%b done=%b pwr=%h code=%h err=%b state=%0d, want all 0",
                  o_busy, o_done, o_pwr, o_code, o_err_multi, o_state);
      else pass_cnt++;
      i_adc_valid = 1'b0;
      #14;
      rst_n = 1'b1;
      tick;
      run_det(8'h33, 8'd2, 8'd4, 8'd8, 8'd12, 8'd16, 1'b0, 1'b0, 0, 0,
              d_cyc, d_pwr, d_code, d_busy, d_bafter, d_st);
      check_cnt++;
      if (d_pwr !== 8'd10) $display("FAIL rstmid_fresh_pwr: got %0d want 10", d_pwr); else pass_cnt++;
      check_cnt++;
      if (d_cyc !== 7) $display("FAIL rstmid_fresh_done: got %0d want 7", d_cyc); else pass_cnt++;
   endtask

`ifdef TUNER_PHY_DETECT_PEAK_EN
   task automatic test_peak;
      logic [7:0] vals [4];
      vals = '{8'd50, 8'd80, 8'd80, 8'd30};
      for (int k = 0; k < 4; k++) begin
         run_det(8'(k + 1), 8'd1, vals[k], vals[k], vals[k], vals[k], 1'b0, 1'b0, 0, 0,
                 d_cyc, d_pwr, d_code, d_busy, d_bafter, d_st);
         if (k == 0) begin
            check_cnt++;
            if ({o_peak_pwr, o_peak_code} !== {8'd50, 8'd1})
               $display("FAIL peak_first: got %0d/%0d want 50/1", o_peak_pwr, o_peak_code);
            else pass_cnt++;
         end
      end
      check_cnt++;
      if ({o_peak_pwr, o_peak_code} !== {8'd80, 8'd2})
         $display("FAIL peak_final: got %0d/%0d want 80/2", o_peak_pwr, o_peak_code);
      else pass_cnt++;
      i_peak_clr = 1'b1;
      tick;
      i_peak_clr = 1'b0;
      check_cnt++;
      if ({o_peak_pwr, o_peak_code} !== 16'd0)
         $display("FAIL peak_clear: got %0d/%0d want 0/0", o_peak_pwr, o_peak_code);
      else pass_cnt++;
   endtask
`endif

   initial begin
      i_start = 1'b0; i_code = 8'h00; i_cfg_wait = 8'd0;
      i_adc_valid = 1'b0; i_adc_data = 8'h00; i_err_clr = 1'b0;
`ifdef TUNER_PHY_DETECT_PEAK_EN
      i_peak_clr = 1'b0;
`endif
      test_reset;
      test_settled;
      test_zero_wait;
      test_gapped;
      test_start_while_busy;
      test_reset_mid;
`ifdef TUNER_PHY_DETECT_PEAK_EN
      test_peak;
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
